// File: rtl/instr_encoder.sv
// SLC-3 field-to-word encoder and program-memory writer.
// States: IDLE (accepting bundles / pointer loads) | WRITE (mem_we held until ack or timeout).
module instr_encoder #(
  parameter int ADDR_W      = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [2:0]        dest,
  input  logic [2:0]        src1,
  input  logic [2:0]        src2,
  input  logic              imm5_sel,
  input  logic [4:0]        imm5,
  input  logic              jsr_sel,
  input  logic [5:0]        offset6,
  input  logic [8:0]        offset9,
  input  logic [10:0]       offset11,
  input  logic [11:0]       ledVect12,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              clear_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  input  logic              mem_ack,
  output logic [15:0]       word_count,
  output logic              timeout_err,
  output logic              busy
);
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [15:0]       data_q;
  logic [15:0]       count_q;
  logic              err_q;
  logic [TW-1:0]     tmr_q;
  logic [15:0]       enc_d;
  logic              timeout;

  always_comb begin
    enc_d = 16'h0000;
    case (opcode)
      4'b0001, 4'b0101: enc_d = imm5_sel ? {opcode, dest, src1, 1'b1, imm5}
                                         : {opcode, dest, src1, 3'b000, src2};
      4'b1001: enc_d = {opcode, dest, src1, 6'b111111};
      4'b0000, 4'b0010, 4'b0011, 4'b1010, 4'b1011, 4'b1110:
               enc_d = {opcode, dest, offset9};
      4'b0110, 4'b0111: enc_d = {opcode, dest, src1, offset6};
      4'b1100: enc_d = {opcode, 3'b000, src1, 6'b000000};
      4'b0100: enc_d = jsr_sel ? {opcode, 1'b1, offset11}
                               : {opcode, 3'b000, src1, 6'b000000};
      4'b1000: enc_d = 16'h8000;
      4'b1101: enc_d = {opcode, ledVect12};
      4'b1111: enc_d = {opcode, 4'b0000, offset9[7:0]};
      default: enc_d = 16'h0000;
    endcase
  end

  // An ack on the expiry edge takes priority, so timeout requires no ack.
  assign timeout = (state_q == S_WRITE) && !mem_ack && (tmr_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      data_q  <= 16'h0000;
      count_q <= 16'h0000;
      err_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (addr_load) begin
            ptr_q <= addr_in;
          end else if (in_valid) begin
            data_q  <= enc_d;
            tmr_q   <= TW'(ACK_TIMEOUT - 1);
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            ptr_q   <= ptr_q + ADDR_W'(1);
            count_q <= (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            state_q <= S_IDLE;
          end else if (tmr_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (timeout)        err_q <= 1'b1;
      else if (clear_err) err_q <= 1'b0;
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !addr_load;
  assign mem_we      = (state_q == S_WRITE);
  assign busy        = (state_q == S_WRITE);
  assign mem_addr    = ptr_q;
  assign mem_data    = data_q;
  assign word_count  = count_q;
  assign timeout_err = err_q;
endmodule
